quat_mult_sequencer: RTL

- Time-multiplexed Hamilton quaternion multiplier controller: C = A ⊗ B using one shared signed DATA_W×DATA_W multiplier and one accumulator.
- Sequences all 16 partial products over 16 cycles.
- Sits between a quaternion source (valid/ready) and a sink (valid/ready). Used where a fully parallel 16-multiplier quaternion product is too costly in area.

---
 rtl/quat_mult_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/quat_mult_sequencer.sv
// Time-multiplexed Hamilton quaternion multiplier: C = A (x) B computed with a
// single shared signed multiplier and accumulator over 16 cycles.
module quat_mult_sequencer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 2 * DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a0,
    input  logic signed [DATA_W-1:0] a1,
    input  logic signed [DATA_W-1:0] a2,
    input  logic signed [DATA_W-1:0] a3,
    input  logic signed [DATA_W-1:0] b0,
    input  logic signed [DATA_W-1:0] b1,
    input  logic signed [DATA_W-1:0] b2,
    input  logic signed [DATA_W-1:0] b3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  c0,
    output logic signed [OUT_W-1:0]  c1,
    output logic signed [OUT_W-1:0]  c2,
    output logic signed [OUT_W-1:0]  c3,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [3:0]                  step_r;
    logic signed [DATA_W-1:0]    a_r [0:3];
    logic signed [DATA_W-1:0]    b_r [0:3];
    logic signed [OUT_W-1:0]     acc_r [0:3];
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic                        busy_r;

    logic                        accept_s;
    logic [1:0]                  idx_i_s;
    logic [1:0]                  idx_j_s;
    logic [1:0]                  idx_b_s;
    logic signed [DATA_W-1:0]    op_a_s;
    logic signed [DATA_W-1:0]    op_b_s;
    logic signed [2*DATA_W-1:0]  prod_s;
    logic signed [OUT_W-1:0]     prod_ext_s;
    logic signed [OUT_W-1:0]     term_s;

    // Negative Hamilton terms, indexed by step k = {i, j}.
    function automatic logic neg_term(input logic [3:0] k);
        logic neg;
        case (k)
            4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd14: neg = 1'b1;
            default:                             neg = 1'b0;
        endcase
        return neg;
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign c0        = acc_r[0];
    assign c1        = acc_r[1];
    assign c2        = acc_r[2];
    assign c3        = acc_r[3];

    assign accept_s  = (state_r == ST_IDLE) && in_valid && in_ready_r;
    assign idx_i_s   = step_r[3:2];
    assign idx_j_s   = step_r[1:0];
    assign idx_b_s   = idx_i_s ^ idx_j_s;

    // Next-state decode of the IDLE -> CALC -> DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_CALC;
                else          state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (step_r == 4'd15) state_s = ST_DONE;
                else                 state_s = ST_CALC;
            end
            ST_DONE: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Shared multiplier and signed partial-product term for the current step.
    always_comb begin
        op_a_s     = a_r[idx_j_s];
        op_b_s     = b_r[idx_b_s];
        prod_s     = op_a_s * op_b_s;
        prod_ext_s = OUT_W'(prod_s);
        if (neg_term(step_r)) term_s = -prod_ext_s;
        else                  term_s = prod_ext_s;
    end

    // State, step counter and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            step_r      <= 4'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s == ST_CALC);
            if (accept_s)                  step_r <= 4'd0;
            else if (state_r == ST_CALC)   step_r <= step_r + 4'd1;
            else                           step_r <= step_r;
        end
    end

    // Operand capture and per-component accumulation; results hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                a_r[i]   <= '0;
                b_r[i]   <= '0;
                acc_r[i] <= '0;
            end
        end else if (accept_s) begin
            a_r[0] <= a0;
            a_r[1] <= a1;
            a_r[2] <= a2;
            a_r[3] <= a3;
            b_r[0] <= b0;
            b_r[1] <= b1;
            b_r[2] <= b2;
            b_r[3] <= b3;
            for (int i = 0; i < 4; i++) acc_r[i] <= '0;
        end else if (state_r == ST_CALC) begin
            for (int i = 0; i < 4; i++) begin
                if (idx_i_s == 2'(i)) acc_r[i] <= acc_r[i] + term_s;
                else                  acc_r[i] <= acc_r[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) acc_r[i] <= acc_r[i];
        end
    end

endmodule
